// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU external memory bus, imported by the
// responder and by the CPU side.
package mem_bus_pkg;

    localparam int   DATA_W    = 64;
    localparam logic ACTIVE_LO = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        RD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_bus_responder_mem_array.sv
// Single-port word RAM with a registered read port (read-before-write),
// contents are not reset.
module mem_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the multiplexed CPU bus. Optional write
// protection of the top of the array is enabled with MEM_PROTECT_EN.
//
// state | meaning
// IDLE  | waiting for nALE
// ADDR  | address latched, waiting for nME
// WAIT  | wait-state countdown
// RD    | read data presented, ENB follows nME/nOE
// WR    | write committed on entry edge
// DONE  | write finished, waiting for nME release
module mem_bus_responder #(
    parameter int DATA_W      = mem_bus_pkg::DATA_W,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2,
    parameter int PROT_BASE   = 'h380
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              ENB,
    input  logic              nALE,
    input  logic              nME,
    input  logic              RnW,
    input  logic              nOE,
    output logic              Busy,
    output logic              Prot_fault
);

    import mem_bus_pkg::*;

    localparam logic [3:0]        WS_CNT    = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_BASE);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         cnt_q;
    logic               dir_rd_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               enb_q;
    logic               busy_q;
    logic               prot_q;
    logic               latch_addr;
    logic               load_cnt;
    logic               wr_go;
    logic               blocked;
    logic               we;
    logic               drive_bus;
    logic [DATA_W-1:0]  rdata;

    // nALE has priority over everything: it aborts and restarts the cycle.
    always_comb begin
        state_d    = state_q;
        latch_addr = 1'b0;
        load_cnt   = 1'b0;
        if (nALE == ACTIVE_LO) begin
            state_d    = ADDR;
            latch_addr = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ADDR: begin
                    if (nME == ACTIVE_LO) begin
                        load_cnt = 1'b1;
                        if (WS_CNT == 4'd0) begin
                            state_d = RnW ? RD : WR;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (nME != ACTIVE_LO) begin
                        state_d = IDLE;
                    end else if (cnt_q == 4'd1) begin
                        state_d = dir_rd_q ? RD : WR;
                    end
                end
                RD, DONE: begin
                    if (nME != ACTIVE_LO) begin
                        state_d = IDLE;
                    end
                end
                WR:      state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_go     = (state_d == WR) && !Reset;
    assign drive_bus = (state_q == RD) && (state_d == RD) &&
                       (nME == ACTIVE_LO) && (nOE == ACTIVE_LO);

`ifdef MEM_PROTECT_EN
    assign blocked = (addr_q >= PROT_ADDR);
`else
    logic unused_prot;
    assign blocked     = 1'b0;
    assign unused_prot = ^PROT_ADDR;
`endif

    assign we = wr_go && !blocked;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            dir_rd_q   <= 1'b0;
            data_out_q <= '0;
            enb_q      <= ~ACTIVE_LO;
            busy_q     <= 1'b0;
            prot_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_addr) begin
                addr_q <= Data_in[ADDR_W-1:0];
            end
            if (load_cnt) begin
                cnt_q    <= WS_CNT;
                dir_rd_q <= RnW;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // RAM read data arrives one cycle after RD entry
            if (state_q == RD) begin
                data_out_q <= rdata;
            end
            enb_q  <= drive_bus ? ACTIVE_LO : ~ACTIVE_LO;
            busy_q <= (state_d != IDLE);
            prot_q <= wr_go && blocked;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .Clock (Clock),
        .we    (we),
        .addr  (addr_q),
        .wdata (Data_in),
        .rdata (rdata)
    );

    assign Data_out   = data_out_q;
    assign ENB        = enb_q;
    assign Busy       = busy_q;
    assign Prot_fault = prot_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two responders (0 and 2 wait states) share
// one bus stimulus and are checked against a word-array reference model.
module tb_mem_bus_responder;

    localparam int ADDR_W    = 10;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NCYC      = 5;
    localparam int PROT_BASE = 'h380;
`ifdef MEM_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        n_ale, n_me, rn_w, n_oe;
    logic [63:0] dout0, dout2;
    logic        enb0, enb2, busy0, busy2, pf0, pf2;

    always #5 clk = ~clk;

    mem_bus_responder #(.WAIT_STATES(0)) dut0 (
        .Clock(clk), .Reset(rst), .Data_in(data_in), .Data_out(dout0), .ENB(enb0),
        .nALE(n_ale), .nME(n_me), .RnW(rn_w), .nOE(n_oe), .Busy(busy0), .Prot_fault(pf0)
    );

    mem_bus_responder #(.WAIT_STATES(2)) dut2 (
        .Clock(clk), .Reset(rst), .Data_in(data_in), .Data_out(dout2), .ENB(enb2),
        .nALE(n_ale), .nME(n_me), .RnW(rn_w), .nOE(n_oe), .Busy(busy2), .Prot_fault(pf2)
    );

    logic [63:0] mem_m [2][DEPTH];
    bit          known [2][DEPTH];
    int          wr_list [$];
    int          compared   = 0;
    int          mismatched = 0;

    function automatic int ws(int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [63:0] o_dout(int d);
        return (d == 0) ? dout0 : dout2;
    endfunction

    function automatic logic o_enb(int d);
        return (d == 0) ? enb0 : enb2;
    endfunction

    function automatic logic o_busy(int d);
        return (d == 0) ? busy0 : busy2;
    endfunction

    function automatic logic o_pf(int d);
        return (d == 0) ? pf0 : pf2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s[ws%0d]: observed %h expected %h", tag, ws(d), obs, exp);
        end
    endtask

    task automatic check_idle(string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_busy"}, d, 64'(o_busy(d)), 64'd0);
            check({tag, "_enb"},  d, 64'(o_enb(d)),  64'd1);
            check({tag, "_prot"}, d, 64'(o_pf(d)),   64'd0);
        end
    endtask

    task automatic latch(logic [63:0] a, bit me_low);
        n_ale   = 1'b0;
        n_me    = !me_low;
        n_oe    = 1'b1;
        data_in = a;
        step();
        n_ale = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check("latch_busy", d, 64'(o_busy(d)), 64'd1);
            check("latch_enb",  d, 64'(o_enb(d)),  64'd1);
            check("latch_prot", d, 64'(o_pf(d)),   64'd0);
        end
    endtask

    // k counts edges from the one that first samples nME low (k = 0).
    task automatic access(bit rd, logic [63:0] wdata, int a);
        bit blocked;
        bit noe_s;
        blocked = PROT_ON && (a >= PROT_BASE);
        n_me    = 1'b0;
        rn_w    = rd;
        data_in = rd ? {$urandom, $urandom} : wdata;
        for (int k = 0; k < NCYC; k++) begin
            noe_s = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            n_oe  = noe_s;
            step();
            for (int d = 0; d < 2; d++) begin
                if (!rd && k == ws(d) && !blocked) begin
                    mem_m[d][a] = wdata;
                    known[d][a] = 1'b1;
                end
                check("busy", d, 64'(o_busy(d)), 64'd1);
                check("enb",  d, 64'(o_enb(d)), (rd && k >= ws(d) + 1 && !noe_s) ? 64'd0 : 64'd1);
                check("prot", d, 64'(o_pf(d)), (!rd && k == ws(d) && blocked) ? 64'd1 : 64'd0);
                if (rd && k >= ws(d) + 1 && known[d][a])
                    check("rdata", d, o_dout(d), mem_m[d][a]);
            end
        end
    endtask

    task automatic release_bus();
        n_me = 1'b1;
        n_oe = 1'b1;
        step();
        check_idle("release");
    endtask

    task automatic wr(logic [63:0] a, logic [63:0] v);
        int wa;
        wa = int'(a[ADDR_W-1:0]);
        latch(a, 1'b0);
        access(1'b0, v, wa);
        release_bus();
        if (!(PROT_ON && wa >= PROT_BASE))
            wr_list.push_back(wa);
    endtask

    task automatic rd(logic [63:0] a, bit me_low);
        latch(a, me_low);
        access(1'b1, '0, int'(a[ADDR_W-1:0]));
        release_bus();
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] v;

        rst = 1'b1; n_ale = 1'b1; n_me = 1'b1; rn_w = 1'b1; n_oe = 1'b1; data_in = '0;
        step();
        step();
        check_idle("reset");
        for (int d = 0; d < 2; d++)
            check("reset_dout", d, o_dout(d), 64'd0);
        rst = 1'b0;
        step();

        // basic write/read and address wrap
        wr(64'h10, 64'hDEADBEEF_CAFEF00D);
        rd(64'h10, 1'b0);
        wr(64'h405, 64'h1);
        rd(64'h005, 1'b0);
        rd(64'hFFFF_0000_0000_0010, 1'b1);

        // back-to-back cycles
        wr(64'h1, 64'h0101_0101_0101_0101);
        wr(64'h2, 64'h0202_0202_0202_0202);
        rd(64'h1, 1'b0);
        rd(64'h2, 1'b0);

        // abort a write to 0x30 by a new address phase targeting 0x20
        wr(64'h30, 64'h3030);
        wr(64'h20, 64'h2020);
        latch(64'h30, 1'b0);
        n_me = 1'b0; rn_w = 1'b0; data_in = 64'hBAD0;
        step();
        mem_m[0]['h30] = 64'hBAD0;
        for (int d = 0; d < 2; d++)
            check("abort_enb", d, 64'(o_enb(d)), 64'd1);
        n_ale = 1'b0; n_me = 1'b1; data_in = 64'h20;
        step();
        n_ale = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check("relatch_busy", d, 64'(o_busy(d)), 64'd1);
            check("relatch_enb",  d, 64'(o_enb(d)),  64'd1);
        end
        access(1'b1, '0, 'h20);
        release_bus();
        rd(64'h30, 1'b0);

        // reset while a write is still counting down
        wr(64'h40, 64'h4040);
        latch(64'h40, 1'b0);
        n_me = 1'b0; rn_w = 1'b0; data_in = 64'h7777;
        step();
        mem_m[0]['h40] = 64'h7777;
        rst = 1'b1;
        step();
        rst = 1'b0; n_me = 1'b1;
        check_idle("midreset");
        for (int d = 0; d < 2; d++)
            check("midreset_dout", d, o_dout(d), 64'd0);
        rd(64'h40, 1'b0);
        rd(64'h10, 1'b0);

        // protected region boundary
        wr(64'h3FF, 64'h55);
        rd(64'h3FF, 1'b0);
        wr(64'h37F, 64'hABC);
        rd(64'h37F, 1'b0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0 || wr_list.size() == 0) begin
                a = {$urandom, $urandom};
                v = {$urandom, $urandom};
                wr(a, v);
            end else begin
                a = {$urandom, $urandom};
                a[ADDR_W-1:0] = ADDR_W'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                rd(a, 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU external bus: multiplexed 64-bit Data bus, strobes nME, nALE, RnW and nOE.
- Latches the word address during the nALE phase and decodes the cycle type.
- Serves reads from, and commits writes to, an internal single-port word array after a fixed number of wait states.
- Data is split into Data_in/Data_out/ENB; the board-level wrapper owns the tri-state (drives Data when ENB==0, otherwise Z).

Parameters:
- DATA_W, 64, bus and word width.
- ADDR_W, 10, word-address bits taken from Data_in[ADDR_W-1:0]; array depth is 2**ADDR_W.
- WAIT_STATES, 2, cycles from nME low to read data valid or write commit; legal range 0..15.
- PROT_BASE, 'h380, first protected word address; used only with MEM_PROTECT_EN.

Ports:
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Data_in  in  DATA_W  bus value as seen by the responder.
- Data_out  out  DATA_W  read data presented to the bus.
- ENB  out  1  active-low output enable for Data_out.
- nALE  in  1  active-low address latch strobe.
- nME  in  1  active-low memory cycle enable.
- RnW  in  1  1 = read, 0 = write; sampled with nME.
- nOE  in  1  active-low output enable request from the CPU.
- Busy  out  1  high from address latch until the cycle ends.
- Prot_fault  out  1  one-cycle pulse on a blocked write; tied 0 without MEM_PROTECT_EN.

Behaviour:
- Reset: state=IDLE, Data_out=0, ENB=1, Busy=0, Prot_fault=0, wait counter=0, address register=0. Array contents are retained and are not cleared.
- States: IDLE, ADDR, WAIT, RD, WR, DONE.
- IDLE: on a sampled nALE==0, latch addr=Data_in[ADDR_W-1:0] and go to ADDR; Busy=1 from the next cycle. Upper address bits are ignored, so addresses wrap modulo 2**ADDR_W.
- ADDR: hold while nME==1. On nME==0, capture RnW into a direction flag and load cnt=WAIT_STATES.
  - cnt==0: go directly to RD (read) or WR (write).
  - otherwise: go to WAIT.
- WAIT: decrement cnt each cycle; on reaching 0, enter RD or WR per the direction flag.
  - Latency: data is valid on Data_out WAIT_STATES+1 cycles after the edge on which nME==0 is first sampled.
- RD:
  - Data_out=mem[addr], loaded on entry and held.
  - ENB=0 exactly while nME==0 and nOE==0 (registered, so it lags the inputs by one cycle); ENB=1 otherwise.
- WR: on the entry edge, mem[addr]<=Data_in if nME==0 and RnW==0, then go to DONE. Exactly one write per cycle.
- DONE and RD: when nME==1 is sampled, go to IDLE with Busy=0 and ENB=1 on the next edge.
- Abort: nME deasserting in ADDR or WAIT returns to IDLE with no array access.
- nALE==0 sampled in any non-IDLE state:
  - aborts the current cycle (pending write discarded);
  - re-latches the address;
  - goes to ADDR, with ENB=1 the following cycle.
- RnW change after capture is ignored until the next address phase.
- Reset asserted mid-cycle: the in-flight write is dropped, ENB=1 on the next edge, and no array write occurs on the reset edge.
- ENB is never 0 outside RD; this avoids bus contention during the address phase.
- nALE and nME both low on the same edge in IDLE: latch the address only; nME is evaluated on the next cycle in ADDR.

Optional Feature:
- Macro: MEM_PROTECT_EN.
- Defined: a write with addr>=PROT_BASE does not modify the array. Prot_fault pulses high for one cycle on the WR entry edge, and the FSM proceeds to DONE as normal.
- Undefined: all addresses are writable, Prot_fault is constant 0, and PROT_BASE is unused.

Decomposition:
- Shared package mem_bus_pkg:
  - DATA_W constant (64);
  - state enum type (IDLE, ADDR, WAIT, RD, WR, DONE);
  - bus polarity constants (ACTIVE_LO=1'b0).
- The CPU side also imports this package.
- One sub-module, mem_array: synchronous single-port RAM, parameters DATA_W/ADDR_W, ports Clock, we, addr, wdata, rdata, with registered read. The FSM accounts for its one-cycle read latency within the WAIT/RD entry timing.

Test Plan:
- Write/read, WAIT_STATES=2: nALE low with Data=0x10, write 0xDEADBEEF_CAFEF00D, then read 0x10 with nOE low.
  - Data_out=0xDEADBEEF_CAFEF00D.
  - ENB=0 only in RD while nOE is low, first valid 3 cycles after nME falls.
- Wrap: write 0x1 at address 0x405, read at 0x005 -> returns 0x1.
- Abort: nME falls, then nALE falls in WAIT with Data=0x20 during a write to 0x30.
  - mem[0x30] unchanged; new cycle targets 0x20.
  - ENB stays 1 throughout.
- Reset mid-cycle: assert Reset in WR-bound WAIT.
  - Next cycle: state IDLE, ENB=1, Busy=0.
  - Target word unchanged; previously written words are intact.
- WAIT_STATES=0: read data is valid 1 cycle after nME falls; back-to-back cycles to 0x1 and 0x2 return their respective contents with no contention.
- MEM_PROTECT_EN: write 0x55 to 0x3FF.
  - Prot_fault pulses for 1 cycle; a subsequent read of 0x3FF returns the old value.
  - A write to 0x37F succeeds with Prot_fault=0.
